// File: rtl/mfe_lcd_hd44780_controller.sv
// ---------------------------------------------------------------------------
// mfe_lcd_hd44780_controller
//
// HD44780-class character-LCD bus controller. Takes one command/data byte per
// vld/ready handshake and sequences RS/RW/EN/data with programmable address
// setup, enable pulse width, inter-nibble gap and execution wait. Supports an
// 8-bit or 4-bit LCD bus; in 4-bit mode a byte goes out high nibble first, or
// as a single high nibble when nib is set (used during 4-bit init).
//
// Optional feature (macro MFE_LCD_BUSY_FLAG_EN): the fixed execution wait is
// replaced by busy-flag polling, with T_LW+1 cycles as the poll timeout.
// Without the macro, lcd_rw is tied 0, lcd_data_oe tied 1 and lcd_data_i is
// unused.
//
// Parameters:
//   BUS_WIDTH  LCD data bus width, 8 or 4
//   T_AS       address setup cycles minus 1
//   T_PW       EN high cycles minus 1
//   T_NG       EN-low gap between nibbles minus 1 (4-bit only)
//   T_SW       short execution wait minus 1
//   T_LW       long execution wait minus 1; also busy-poll timeout
//   T_WIDTH    timer width
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd, dat, nib, lwt  request fields, latched on vld && ready
//   vld, ready          request handshake; ready is high only in IDLE
//   lcd_rs, lcd_rw      register select, read/write select
//   lcd_en              registered enable strobe
//   lcd_data_o/_i/_oe   data pins out, data pins in, output enable
// ---------------------------------------------------------------------------
module mfe_lcd_hd44780_controller #(
   parameter int BUS_WIDTH = 8,
   parameter int T_AS      = 6,
   parameter int T_PW      = 24,
   parameter int T_NG      = 24,
   parameter int T_SW      = 5000,
   parameter int T_LW      = 180000,
   parameter int T_WIDTH   = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd,
   input  logic [7:0]           dat,
   input  logic                 nib,
   input  logic                 lwt,
   input  logic                 vld,
   output logic                 ready,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_en,
   output logic [BUS_WIDTH-1:0] lcd_data_o,
   input  logic [BUS_WIDTH-1:0] lcd_data_i,
   output logic                 lcd_data_oe
);

   localparam bit FOUR_BIT = (BUS_WIDTH == 4);

   localparam logic [T_WIDTH-1:0] LIM_AS = T_WIDTH'(T_AS);
   localparam logic [T_WIDTH-1:0] LIM_PW = T_WIDTH'(T_PW);
   localparam logic [T_WIDTH-1:0] LIM_NG = T_WIDTH'(T_NG);
   localparam logic [T_WIDTH-1:0] LIM_SW = T_WIDTH'(T_SW);
   localparam logic [T_WIDTH-1:0] LIM_LW = T_WIDTH'(T_LW);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      GAP,
      WAIT,
      BF_SETUP,
      BF_PULSE,
      BF_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [T_WIDTH-1:0]   timer_q, timer_d;
   logic                 cmd_q, cmd_d;
   logic [7:0]           dat_q, dat_d;
   logic                 nib_q, nib_d;
   logic                 lwt_q, lwt_d;
   logic                 phase_q, phase_d;
   logic                 lcd_en_q, lcd_en_d;
   logic [T_WIDTH-1:0]   wait_lim;

`ifdef MFE_LCD_BUSY_FLAG_EN
   logic                 busy_q, busy_d;
   logic [T_WIDTH-1:0]   poll_q, poll_d;
   logic                 polling;
   logic                 busy_now;
   logic                 unused_lwt;

   assign polling    = (state_q == BF_SETUP) || (state_q == BF_PULSE) ||
                       (state_q == BF_GAP);
   // 8-bit polls decide on the live pin; 4-bit polls use the flag captured
   // during the first (high-nibble) read pulse.
   assign busy_now   = FOUR_BIT ? busy_q : lcd_data_i[BUS_WIDTH-1];
   assign unused_lwt = lwt_q;
`else
   logic                 unused_data_i;
   assign unused_data_i = ^lcd_data_i;
`endif

   assign wait_lim = lwt_q ? LIM_LW : LIM_SW;

   // Next-state, request latching and timer control.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      dat_d    = dat_q;
      nib_d    = nib_q;
      lwt_d    = lwt_q;
      phase_d  = phase_q;
`ifdef MFE_LCD_BUSY_FLAG_EN
      busy_d   = busy_q;
      poll_d   = polling ? (poll_q + T_WIDTH'(1)) : '0;
`endif

      case (state_q)
         IDLE: begin
            if (vld) begin
               state_d = SETUP;
               cmd_d   = cmd;
               dat_d   = dat;
               nib_d   = nib;
               lwt_d   = lwt;
               phase_d = 1'b0;
            end
         end
         SETUP: begin
            if (timer_q == LIM_AS) begin
               state_d = PULSE;
            end
         end
         PULSE: begin
            if (timer_q == LIM_PW) begin
               if (FOUR_BIT && !phase_q && !nib_q) begin
                  state_d = GAP;
               end else begin
`ifdef MFE_LCD_BUSY_FLAG_EN
                  state_d = BF_SETUP;
                  phase_d = 1'b0;
`else
                  state_d = WAIT;
`endif
               end
            end
         end
         GAP: begin
            // The nibble select flips only here, once EN has fallen, so the
            // high nibble stays on the pins for the whole registered pulse.
            if (timer_q == LIM_NG) begin
               state_d = SETUP;
               phase_d = 1'b1;
            end
         end
         WAIT: begin
            if (timer_q == wait_lim) begin
               state_d = IDLE;
            end
         end
`ifdef MFE_LCD_BUSY_FLAG_EN
         BF_SETUP: begin
            if (timer_q == LIM_AS) begin
               state_d = BF_PULSE;
            end
         end
         BF_PULSE: begin
            if (timer_q == LIM_PW) begin
               if (FOUR_BIT && !phase_q) begin
                  state_d = BF_GAP;
                  busy_d  = lcd_data_i[BUS_WIDTH-1];
               end else begin
                  state_d = busy_now ? BF_SETUP : IDLE;
                  phase_d = 1'b0;
               end
            end
         end
         BF_GAP: begin
            if (timer_q == LIM_NG) begin
               state_d = BF_PULSE;
               phase_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef MFE_LCD_BUSY_FLAG_EN
      // A stuck busy flag must not hang the sequencer.
      if (polling && (poll_q == LIM_LW)) begin
         state_d = IDLE;
         phase_d = 1'b0;
      end
`endif

      if ((state_q == IDLE) || (state_d != state_q)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + T_WIDTH'(1);
      end

      // EN follows the state one cycle late, giving a glitch-free pin.
      lcd_en_d = (state_q == PULSE) || (state_q == BF_PULSE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         cmd_q    <= 1'b1;
         dat_q    <= '0;
         nib_q    <= 1'b0;
         lwt_q    <= 1'b0;
         phase_q  <= 1'b0;
         lcd_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cmd_q    <= cmd_d;
         dat_q    <= dat_d;
         nib_q    <= nib_d;
         lwt_q    <= lwt_d;
         phase_q  <= phase_d;
         lcd_en_q <= lcd_en_d;
      end
   end

`ifdef MFE_LCD_BUSY_FLAG_EN
   // Busy-poll bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         poll_q <= '0;
      end else begin
         busy_q <= busy_d;
         poll_q <= poll_d;
      end
   end

   assign lcd_rs      = polling ? 1'b0 : ~cmd_q;
   assign lcd_rw      = polling;
   assign lcd_data_oe = ~polling;
`else
   assign lcd_rs      = ~cmd_q;
   assign lcd_rw      = 1'b0;
   assign lcd_data_oe = 1'b1;
`endif

   assign ready  = (state_q == IDLE);
   assign lcd_en = lcd_en_q;

   generate
      if (BUS_WIDTH == 8) begin : g_bus8
         assign lcd_data_o = dat_q;
      end else begin : g_bus4
         assign lcd_data_o = phase_q ? dat_q[3:0] : dat_q[7:4];
      end
   endgenerate

endmodule
